vp_delay_line: RTL and testbench

- Parametrised successor to the video pipeline's fixed two-stage attribute delay.
- Delays an arbitrary-width attribute word by a run-time-selectable number of clocks, 1..DEPTH.
- Tracks a valid bit per stage and supports stall and flush.
- Sits between the character/attribute fetch and the text renderer; aligns attribute words with pattern/font lookups of differing latency.

---
 rtl/vp_delay_line.sv | 118 +++++++++++
 tb/tb_vp_delay_line.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vp_delay_line.sv
// Attribute-word delay line with per-stage valid, run-time delay select (1..DEPTH), stall and flush.
// Define VP_DELAY_LINE_OUTREG_EN to register the selected tap (latency eff+1).
module vp_delay_line #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4,
`ifdef VP_DELAY_LINE_OUTREG_EN
    localparam int unsigned SELW = $clog2(DEPTH + 2)
`else
    localparam int unsigned SELW = $clog2(DEPTH + 1)
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  delay_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  occupancy
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]             eff;
    logic                        tap_valid;
    logic [WIDTH-1:0]            tap_data;
    logic [SELW-1:0]             occ_stages;

    // Clamp the requested delay into 1..DEPTH.
    always_comb begin
        eff = delay_sel;
        if (delay_sel == '0) begin
            eff = SELW'(1);
        end else if (delay_sel > SELW'(DEPTH)) begin
            eff = SELW'(DEPTH);
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
            data_d  = '0;
        end else if (!stall) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Tap mux and occupancy over stages 1..eff; stage i+1 lives at index i.
    always_comb begin
        tap_valid  = 1'b0;
        tap_data   = '0;
        occ_stages = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (SELW'(i + 1) == eff) begin
                tap_valid = valid_q[i];
                tap_data  = valid_q[i] ? data_q[i] : '0;
            end
            if (SELW'(i) < eff) begin
                occ_stages = occ_stages + SELW'(valid_q[i]);
            end
        end
    end

`ifdef VP_DELAY_LINE_OUTREG_EN
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else if (!stall) begin
            out_valid_d = tap_valid;
            out_data_d  = tap_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occupancy = occ_stages + SELW'(out_valid_q);
`else
    assign out_valid = tap_valid;
    assign out_data  = tap_data;
    assign occupancy = occ_stages;
`endif

endmodule

// File: tb/tb_vp_delay_line.sv
// Directed bench for vp_delay_line in its default (combinational tap) build, WIDTH=48, DEPTH=4.
module tb_vp_delay_line;

    localparam int unsigned WIDTH = 48;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SELW  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset, stall, flush, in_valid;
    logic [WIDTH-1:0] in_data;
    logic [SELW-1:0]  delay_sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    vp_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .delay_sel (delay_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one input word, advance one edge, settle for sampling.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                              input logic [SELW-1:0] occ);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_data"},  64'(out_data),  64'(d));
        check({tag, "_occ"},   64'(occupancy), 64'(occ));
    endtask

    task automatic drain();
        for (int i = 0; i < int'(DEPTH); i++) cyc(1'b0, '0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_data = '1; delay_sel = SELW'(2);

        // 1: reset with live all-ones input
        @(posedge clk); #1;
        expect_out("rst1", 1'b0, '0, '0);
        @(posedge clk); #1;
        expect_out("rst2", 1'b0, '0, '0);
        reset = 1'b0;
        cyc(1'b0, '0);
        expect_out("rst_rel", 1'b0, '0, '0);

        // 2: delay 2, words 1,2,3
        cyc(1'b1, 48'h1); expect_out("d2_e1", 1'b0, '0,    SELW'(1));
        cyc(1'b1, 48'h2); expect_out("d2_e2", 1'b1, 48'h1, SELW'(2));
        cyc(1'b1, 48'h3); expect_out("d2_e3", 1'b1, 48'h2, SELW'(2));
        cyc(1'b0, '0);    expect_out("d2_e4", 1'b1, 48'h3, SELW'(1));
        cyc(1'b0, '0);    expect_out("d2_e5", 1'b0, '0,    SELW'(0));

        // 3: delay_sel 0 -> 1, delay_sel 7 -> 4
        drain();
        delay_sel = SELW'(0);
        cyc(1'b1, 48'h11); expect_out("d0_e1", 1'b1, 48'h11, SELW'(1));
        cyc(1'b0, '0);     expect_out("d0_e2", 1'b0, '0,     SELW'(0));
        delay_sel = SELW'(7);
        drain();
        expect_out("d7_clear", 1'b0, '0, SELW'(0));
        cyc(1'b1, 48'h22); expect_out("d7_e1", 1'b0, '0,     SELW'(1));
        cyc(1'b0, '0);     expect_out("d7_e2", 1'b0, '0,     SELW'(1));
        cyc(1'b0, '0);     expect_out("d7_e3", 1'b0, '0,     SELW'(1));
        cyc(1'b0, '0);     expect_out("d7_e4", 1'b1, 48'h22, SELW'(1));
        cyc(1'b0, '0);     expect_out("d7_e5", 1'b0, '0,     SELW'(0));

        // 4: stall for 3 clocks after 0xB enters
        delay_sel = SELW'(2);
        drain();
        cyc(1'b1, 48'hA); expect_out("st_a", 1'b0, '0,    SELW'(1));
        cyc(1'b1, 48'hB); expect_out("st_b", 1'b1, 48'hA, SELW'(2));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 48'hEE);
            expect_out("st_hold", 1'b1, 48'hA, SELW'(2));
        end
        stall = 1'b0;
        cyc(1'b1, 48'hC); expect_out("st_r1", 1'b1, 48'hB, SELW'(2));
        cyc(1'b0, '0);    expect_out("st_r2", 1'b1, 48'hC, SELW'(1));
        cyc(1'b0, '0);    expect_out("st_r3", 1'b0, '0,    SELW'(0));

        // 5: flush together with stall, 3 words in flight at delay 4
        delay_sel = SELW'(4);
        drain();
        cyc(1'b1, 48'h31);
        cyc(1'b1, 48'h32);
        cyc(1'b1, 48'h33);
        expect_out("fl_pre", 1'b0, '0, SELW'(3));
        flush = 1'b1; stall = 1'b1;
        cyc(1'b1, 48'h99); expect_out("fl_edge", 1'b0, '0, SELW'(0));
        flush = 1'b0; stall = 1'b0;
        cyc(1'b1, 48'hD); expect_out("fl_d1", 1'b0, '0,    SELW'(1));
        cyc(1'b0, '0);    expect_out("fl_d2", 1'b0, '0,    SELW'(1));
        cyc(1'b0, '0);    expect_out("fl_d3", 1'b0, '0,    SELW'(1));
        cyc(1'b0, '0);    expect_out("fl_d4", 1'b1, 48'hD, SELW'(1));

        // 6: invalid word with non-zero data is masked
        delay_sel = SELW'(1);
        cyc(1'b0, 48'h55); expect_out("mask", 1'b0, '0, SELW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
